// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/funct encodings and ALU operation set shared by the core
package riscv_pkg;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7, F3_WORD = 3'd2;
  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
  function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: 32-bit RV32I integer ALU
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);
  // one result per operation; shifts use only the low five bits of b
  always_comb
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
endmodule

// File: rtl/riscv_dmem.sv
// riscv_dmem: word-addressed data RAM, synchronous write and asynchronous read
module riscv_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] memory [0:DEPTH-1];
  logic [AW-1:0] idx;
  assign idx = AW'(word_addr % DEPTH);
  assign rdata = memory[idx];
  // store the full word at the clock edge; contents survive reset
  always_ff @(posedge clk)
    if (we) memory[idx] <= wdata;
endmodule

// File: rtl/riscv_imem.sv
// riscv_imem: word-addressed instruction ROM with combinational read, loaded by hierarchy
module riscv_imem #(
  parameter int DEPTH = 256
) (
  input  logic [31:0] word_addr,
  output logic [31:0] rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] memory [0:DEPTH-1];
  assign rdata = memory[AW'(word_addr % DEPTH)];
endmodule

// File: rtl/riscv_cpu_top.sv
// riscv_cpu_top: single-cycle RV32I core with decode, register file and next-PC logic
module riscv_cpu_top
  import riscv_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  logic [31:0] pc, next_pc, pc_plus4, instruction;
  logic [31:0] regs [0:31];
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_y, wb, mem_addr, dm_rdata;
  logic        rf_we, dm_we, taken, legal_reg, legal_imm, alt;
  alu_op_t     alu_op;

  riscv_imem #(.DEPTH(IMEM_WORDS)) imem (.word_addr(pc >> 2), .rdata(instruction));

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign f7     = instruction[31:25];
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u  = {instruction[31:12], 12'd0};
  assign imm_j  = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  assign rs1v     = rs1 == 5'd0 ? 32'd0 : regs[rs1];
  assign rs2v     = rs2 == 5'd0 ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  assign legal_reg = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
  assign legal_imm = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
  assign alt       = opcode == OP_REG ? f7[5] : (f3 == F3_SR && f7[5]);
  assign alu_op    = alu_op_of(f3, alt);

  riscv_alu alu (.a(rs1v), .b(opcode == OP_REG ? rs2v : imm_i), .op(alu_op), .y(alu_y));

  assign mem_addr = rs1v + (opcode == OP_STORE ? imm_s : imm_i);

  riscv_dmem #(.DEPTH(DMEM_WORDS)) dmem (
    .clk(clk), .we(dm_we & reset), .word_addr(mem_addr >> 2), .wdata(rs2v), .rdata(dm_rdata)
  );

  assign taken = f3 == F3_BEQ  ? rs1v == rs2v :
                 f3 == F3_BNE  ? rs1v != rs2v :
                 f3 == F3_BLT  ? $signed(rs1v) <  $signed(rs2v) :
                 f3 == F3_BGE  ? $signed(rs1v) >= $signed(rs2v) :
                 f3 == F3_BLTU ? rs1v <  rs2v :
                 f3 == F3_BGEU ? rs1v >= rs2v : 1'b0;

  // decode: writeback source, store enable and next PC; anything unrecognised falls through as a NOP
  always_comb begin
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    wb      = alu_y;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI:    begin rf_we = 1'b1; wb = imm_u; end
      OP_AUIPC:  begin rf_we = 1'b1; wb = pc + imm_u; end
      OP_JAL:    begin rf_we = 1'b1; wb = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR:   if (f3 == 3'd0) begin rf_we = 1'b1; wb = pc_plus4; next_pc = (rs1v + imm_i) & ~32'd1; end
      OP_BRANCH: next_pc = taken ? pc + imm_b : pc_plus4;
      OP_LOAD:   begin rf_we = f3 == F3_WORD; wb = dm_rdata; end
      OP_STORE:  dm_we = f3 == F3_WORD;
      OP_IMM:    rf_we = legal_imm;
      OP_REG:    rf_we = legal_reg;
      default:   ;
    endcase
  end

  // retire: PC and register write commit together; reset clears them without waiting for a clock
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rf_we && rd != 5'd0) regs[rd] <= wb;
    end
endmodule

// File: tb/tb_riscv_cpu_top.sv
// tb_riscv_cpu_top: directed plus random programs checked against an ISA-level reference model
module tb_riscv_cpu_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_x [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc;

  riscv_cpu_top dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] es(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] eu(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] ej(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // reference interpreter: executes the instruction at m_pc on the architectural state
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, nxt, val;
    logic [4:0] rd, sh;
    logic [2:0] f3;
    logic [6:0] f7;
    logic wr, t;
    ins = m_imem[(m_pc >> 2) % 256];
    rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
    ii = $unsigned($signed(ins) >>> 20);
    is = {ii[31:5], ins[11:7]};
    ib = (ins[31] ? 32'hFFFFF000 : 32'd0) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    iu = ins & 32'hFFFFF000;
    ij = (ins[31] ? 32'hFFF00000 : 32'd0) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    nxt = m_pc + 32'd4; val = 32'd0; wr = 1'b0; t = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; val = iu; end
      7'h17: begin wr = 1'b1; val = m_pc + iu; end
      7'h6f: begin wr = 1'b1; val = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; val = m_pc + 32'd4; nxt = (a + ii) & 32'hFFFFFFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = a == b;
          3'd1: t = a != b;
          3'd4: t = $signed(a) < $signed(b);
          3'd5: t = $signed(a) >= $signed(b);
          3'd6: t = a < b;
          3'd7: t = a >= b;
          default: t = 1'b0;
        endcase
        if (t) nxt = m_pc + ib;
      end
      7'h03: if (f3 == 3'd2) begin wr = 1'b1; val = m_dmem[((a + ii) >> 2) % 256]; end
      7'h23: if (f3 == 3'd2) m_dmem[((a + is) >> 2) % 256] = b;
      7'h13: begin
        sh = ins[24:20];
        case (f3)
          3'd0: begin wr = 1'b1; val = a + ii; end
          3'd1: if (f7 == 7'h00) begin wr = 1'b1; val = a << sh; end
          3'd2: begin wr = 1'b1; val = {31'd0, $signed(a) < $signed(ii)}; end
          3'd3: begin wr = 1'b1; val = {31'd0, a < ii}; end
          3'd4: begin wr = 1'b1; val = a ^ ii; end
          3'd5: if (f7 == 7'h00) begin wr = 1'b1; val = a >> sh; end
                else if (f7 == 7'h20) begin wr = 1'b1; val = $unsigned($signed(a) >>> sh); end
          3'd6: begin wr = 1'b1; val = a | ii; end
          default: begin wr = 1'b1; val = a & ii; end
        endcase
      end
      7'h33: begin
        sh = b[4:0];
        if (f7 == 7'h00) begin
          wr = 1'b1;
          case (f3)
            3'd0: val = a + b;
            3'd1: val = a << sh;
            3'd2: val = {31'd0, $signed(a) < $signed(b)};
            3'd3: val = {31'd0, a < b};
            3'd4: val = a ^ b;
            3'd5: val = a >> sh;
            3'd6: val = a | b;
            default: val = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin wr = 1'b1; val = a - b; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin wr = 1'b1; val = $unsigned($signed(a) >>> sh); end
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = val;
    m_pc = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", dut.pc, m_pc);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s x%0d", tag, i), dut.regs[i], m_x[i]);
  endtask

  task automatic load_imem();
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = m_imem[i];
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] imm;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    imm = $urandom;
    rd = 5'($urandom_range(0, 15));
    r1 = 5'($urandom_range(0, 15));
    r2 = 5'($urandom_range(0, 15));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0: return eu(imm[19:0], rd, 7'h37);
      1: return eu(imm[19:0], rd, 7'h17);
      2: return ej(imm, rd);
      3: return ei(imm, r1, 3'd0, rd, 7'h67);
      4: return eb(imm, r2, r1, f3);
      5: return ei(imm, r1, 3'd2, rd, 7'h03);
      6: return es(imm, r2, r1, 3'd2);
      7, 8: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
        return ei(imm, r1, f3, rd, 7'h13);
      end
      9, 10: return er((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00, r2, r1, f3, rd);
      11: case ($urandom_range(0, 3))
            0: return 32'h0000000F;
            1: return 32'h00000073;
            2: return ei(imm, r1, 3'd0, rd, 7'h03);
            default: return es(imm, r2, r1, 3'd0);
          endcase
      12: return $urandom;
      default: return ei(32'($urandom_range(0, 63)), r1, 3'd0, rd, 7'h13);
    endcase
  endfunction

  initial begin
    logic [31:0] prog [18];
    prog[0]  = ei(32'd16, 5'd0, 3'd0, 5'd4, 7'h13);
    prog[1]  = ei(32'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    prog[2]  = ei(32'd2, 5'd0, 3'd0, 5'd2, 7'h13);
    prog[3]  = er(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    prog[4]  = er(7'h20, 5'd2, 5'd2, 3'd0, 5'd3);
    prog[5]  = es(32'd0, 5'd1, 5'd4, 3'd2);
    prog[6]  = ei(32'd0, 5'd4, 3'd2, 5'd5, 7'h03);
    prog[7]  = eu(20'h00001, 5'd5, 7'h37);
    prog[8]  = eu(20'h00000, 5'd5, 7'h17);
    prog[9]  = eb(32'd8, 5'd3, 5'd3, 3'd0);
    prog[10] = ei(32'd9, 5'd0, 3'd0, 5'd6, 7'h13);
    prog[11] = ei(32'd2, 5'd0, 3'd0, 5'd7, 7'h13);
    prog[12] = ej(32'd8, 5'd1);
    prog[13] = ei(32'd7, 5'd0, 3'd0, 5'd8, 7'h13);
    prog[14] = ei(32'd4, 5'd0, 3'd0, 5'd9, 7'h13);
    prog[15] = ei(32'd5, 5'd0, 3'd0, 5'd10, 7'h13);
    prog[16] = ei(32'd5, 5'd0, 3'd0, 5'd0, 7'h13);
    prog[17] = es(32'd0, 5'd9, 5'd0, 3'd2);
    for (int i = 0; i < 256; i++) begin
      m_imem[i] = i < 18 ? prog[i] : 32'h00000013;
      m_dmem[i] = $urandom;
    end
    m_dmem[0] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0;
    load_imem();
    for (int i = 0; i < 256; i++) dut.dmem.memory[i] = m_dmem[i];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", dut.pc, 32'h0);
    check_regs("reset");
    reset = 1'b1;
    #1;
    chk("first fetch", dut.instruction, prog[0]);

    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("pc sequence", dut.pc, 32'(4 * k));
    end
    chk("x4", dut.regs[4], 32'd16);
    chk("x1", dut.regs[1], 32'd1);
    chk("x2", dut.regs[2], 32'd2);
    chk("x3 add", dut.regs[3], 32'd3);
    tick(); chk("x3 sub", dut.regs[3], 32'd0);
    tick(); chk("sw dmem[4]", dut.dmem.memory[4], 32'd1);
    tick(); chk("lw x5", dut.regs[5], 32'd1);
    tick(); chk("lui x5", dut.regs[5], 32'h1000);
    chk("pc before auipc", dut.pc, 32'h20);
    tick(); chk("auipc x5", dut.regs[5], 32'h20);
    chk("pc at beq", dut.pc, 32'h24);
    tick(); chk("beq target", dut.pc, 32'h2C);
    tick(); chk("skipped x6", dut.regs[6], 32'd0);
    chk("x7", dut.regs[7], 32'd2);
    tick(); chk("jal target", dut.pc, 32'h38);
    chk("jal link x1", dut.regs[1], 32'h34);
    tick(); chk("skipped x8", dut.regs[8], 32'd0);
    chk("x9", dut.regs[9], 32'd4);
    tick(); chk("x10", dut.regs[10], 32'd5);
    tick(); chk("x0 stays zero", dut.regs[0], 32'd0);
    check_regs("directed");

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async reset pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0;
    check_regs("mid reset");
    @(posedge clk);
    #1;
    chk("aborted sw dmem[0]", dut.dmem.memory[0], 32'hDEADBEEF);
    chk("retained dmem[4]", dut.dmem.memory[4], 32'd1);
    chk("retained imem[3]", dut.imem.memory[3], prog[3]);
    chk("pc held in reset", dut.pc, 32'h0);

    for (int i = 0; i < 256; i++) m_imem[i] = rand_instr();
    load_imem();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (c % 50 == 0) check_regs("random");
    end
    for (int i = 0; i < 256; i++) chk($sformatf("dmem[%0d]", i), dut.dmem.memory[i], m_dmem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_cpu_top.md
RISCV_CPU_TOP -- requirements
Module: riscv_cpu_top

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 256, meaning data-memory depth in 32-bit words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low = in reset.
REQ-006 SHALL have no other ports; observation SHALL be by hierarchy: signals pc[31:0] and instruction[31:0], and instances imem and dmem, each containing word array memory[0:DEPTH-1] of 32 bits.

Function
REQ-007 SHALL be a single-cycle RV32I core: one instruction fetched, decoded, executed and retired per rising clk edge while reset is high.
REQ-008 SHALL fetch instruction = imem.memory[pc[31:2] mod IMEM_WORDS] combinationally; pc[1:0] SHALL be ignored.
REQ-009 SHALL implement LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW and SW.
REQ-010 SHALL implement ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI.
REQ-011 SHALL implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND.
REQ-012 SHALL sign-extend all I/S/B/U/J immediates per the RV32I encoding; arithmetic SHALL be 32-bit wrap-around, with no overflow trap.
REQ-013 SHALL have a 32x32 register file with 2 combinational read ports and 1 write port; x0 SHALL read 0 and writes to it SHALL be discarded.
REQ-014 SHALL set next PC as follows: taken branch and JAL = pc+imm; JALR = (rs1+imm) & ~1; otherwise pc+4.
REQ-015 SHALL write rd = pc+4 for JAL and JALR.
REQ-016 SHALL compute the LW/SW address as rs1+imm and index dmem with addr[31:2] mod DMEM_WORDS; misalignment SHALL be ignored.
REQ-017 SHALL read LW data combinationally and write it to rd at the same edge.
REQ-018 SHALL have SW write the full 32-bit rs2 at the rising edge.
REQ-019 SHALL treat unsupported opcodes (including FENCE/SYSTEM and byte/halfword loads and stores) as NOPs with pc+4; there SHALL be no exceptions.
REQ-020 SHALL apply register-file write, memory write and PC update atomically at the same edge.

Reset
REQ-021 SHALL, while reset is low, asynchronously force pc = RESET_PC and clear x1..x31 to 0.
REQ-022 SHALL NOT reset imem or dmem contents, so they may be preloaded during reset and retained.
REQ-023 SHALL fetch from RESET_PC at the first rising edge after reset deasserts.
REQ-024 SHALL abort the current instruction when reset is asserted mid-program, with no register or memory write.

Structure
REQ-025 SHALL put opcode, funct3/funct7 localparams and the ALU-op enum in shared package riscv_pkg.
REQ-026 SHALL contain sub-modules imem (ROM-style, combinational read) and dmem (sync write, async read).
REQ-027 SHALL use a natural ALU sub-module riscv_alu; decode, regfile and next-PC logic SHALL live in the top.

Verification
REQ-028 Reset then ADDI x4,x0,16; ADDI x1,x0,1; ADDI x2,x0,2; ADD x3,x1,x2 -> x4=16, x1=1, x2=2, x3=3; pc advances 0,4,8,C.
REQ-029 SUB x3,x2,x2 -> x3=0; SW x1,0(x4) -> dmem.memory[4]=1; LW x5,0(x4) -> x5=1.
REQ-030 LUI x5,0x1 -> x5=0x1000; AUIPC x5,0 at pc 0x20 -> x5=0x20.
REQ-031 BEQ x3,x3,8 at 0x24 -> next pc 0x2C, index 10 (ADDI x6) skipped, x6=0, x7=2.
REQ-032 JAL x1,8 at 0x30 -> x1=0x34, pc 0x38, x8=0, x9=4; then ADDI x10,x0,5 -> x10=5.
REQ-033 ADDI x0,x0,5 -> x0 stays 0; reset low mid-run -> pc=0 immediately and registers cleared, memories retained.
